// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   BP_IDX_W / BP_TAG_W : default table index and partial tag widths
//   ctr_e               : 2-bit saturating direction counter encoding
//   pred_t              : one prediction travelling down the F->D->E pipe
//   sat_update          : one saturating step of a direction counter
package bp_pkg;

  localparam int unsigned BP_IDX_W = 4;
  localparam int unsigned BP_TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  function automatic ctr_e sat_update(input ctr_e c, input logic up);
    ctr_e r;
    r = c;
    if (up) begin
      if (c != ST) r = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) r = ctr_e'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor table: valid, partial tag, 2-bit counter, target.
//   clk, rst      : clock, synchronous active-high clear (valid=0, ctr=WNT)
//   rd_idx        : asynchronous read index (fetch side)
//   rd_valid/tag/ctr/target : entry contents at rd_idx
//   wr_en         : resolve-and-train strobe from the execute stage
//   wr_idx/wr_tag : location and tag of the resolved instruction
//   wr_taken      : actual direction; steps the counter on a hit,
//                   allocates a WT entry on a miss when taken
//   wr_target     : actual target, stored whenever wr_taken is set
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned TAG_W = BP_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output ctr_e              rd_ctr,
  output logic [31:0]       rd_target,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_taken,
  input  logic [31:0]       wr_target
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  ctr_e              ctr_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];

  logic wr_hit;

  // Reads see the pre-edge contents; a same-cycle write is not bypassed.
  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_ctr    = ctr_q[rd_idx];
    rd_target = target_q[rd_idx];
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= WNT;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
        if (wr_taken) target_q[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        ctr_q[wr_idx]    <= WT;
        target_q[wr_idx] <= wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor beside the fetch stage of the 5-stage core.
//   PCF -> predict_takenF, pred_targetF : zero-latency fetch prediction
//   StallD, FlushD, FlushE              : hazard unit controls for the pred pipe
//   validE, cflowE, jalrE, takenE, targetE, PCE, PCPlus4E : E-stage outcome
//   mispredictE, redirect_pcE           : execute-stage redirect
//   branch_cnt, mispredict_cnt          : wrapping performance counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned TAG_W = BP_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        predict_takenF,
  output logic [31:0] pred_targetF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        validE,
  input  logic        cflowE,
  input  logic        jalrE,
  input  logic        takenE,
  input  logic [31:0] targetE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  output logic        mispredictE,
  output logic [31:0] redirect_pcE,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = TAG_W + IDX_W + 1;

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  ctr_e             rd_ctr;
  logic [31:0]      rd_target;

  pred_t predD, predE;
  logic  actualE, resolveE, updateE;

  logic unused_bits;

  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[TAG_HI:TAG_LO];
  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[TAG_HI:TAG_LO];

  assign unused_bits = ^{PCF[1:0], PCF[31:TAG_HI+1], PCE[1:0], PCE[31:TAG_HI+1], rd_ctr[0]};

  bp_table #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idxF),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_ctr    (rd_ctr),
    .rd_target (rd_target),
    .wr_en     (updateE),
    .wr_idx    (idxE),
    .wr_tag    (tagE),
    .wr_taken  (actualE),
    .wr_target (targetE)
  );

  always_comb begin
    predict_takenF = rd_valid && (rd_tag == tagF) && rd_ctr[1];
    pred_targetF   = predict_takenF ? rd_target : PCF + 32'd4;
  end

  // StallD freezes both D and E; FlushE still wins for E so a bubble is
  // inserted behind a stalled D instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      predD <= '0;
      predE <= '0;
    end else begin
      if (FlushD)       predD <= '0;
      else if (!StallD) predD <= '{taken: predict_takenF, target: pred_targetF};
      if (FlushE)       predE <= '0;
      else if (!StallD) predE <= predD;
    end
  end

  always_comb begin
    actualE      = cflowE && takenE;
    resolveE     = validE && !jalrE;
    updateE      = validE && cflowE && !jalrE;
    mispredictE  = resolveE &&
                   ((predE.taken != actualE) ||
                    (predE.taken && actualE && (predE.target != targetE)));
    redirect_pcE = actualE ? targetE : PCPlus4E;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (updateE)     branch_cnt     <= branch_cnt + 32'd1;
      if (mispredictE) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed cycle script with
// literal expectations plus a behavioural model checked every cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        predict_takenF;
  logic [31:0] pred_targetF;
  logic        StallD, FlushD, FlushE;
  logic        validE, cflowE, jalrE, takenE;
  logic [31:0] targetE, PCE, PCPlus4E;
  logic        mispredictE;
  logic [31:0] redirect_pcE, branch_cnt, mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .TAG_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCF            (PCF),
    .predict_takenF (predict_takenF),
    .pred_targetF   (pred_targetF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .validE         (validE),
    .cflowE         (cflowE),
    .jalrE          (jalrE),
    .takenE         (takenE),
    .targetE        (targetE),
    .PCE            (PCE),
    .PCPlus4E       (PCPlus4E),
    .mispredictE    (mispredictE),
    .redirect_pcE   (redirect_pcE),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_ready = 0;
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  bit          m_d_taken, m_e_taken;
  logic [31:0] m_d_tgt,   m_e_tgt;
  logic [31:0] m_bcnt,    m_mcnt;

  function automatic int unsigned m_index(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / 64) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[m_index(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_actual();
    return cflowE && takenE;
  endfunction

  function automatic bit m_mis();
    if (!validE || jalrE) return 0;
    if (m_e_taken != m_actual()) return 1;
    return m_e_taken && (m_e_tgt != targetE);
  endfunction

  always @(posedge clk) begin
    bit          pt, mis, act;
    logic [31:0] ptg;
    int unsigned ix;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
      end
      m_d_taken = 0; m_d_tgt = '0; m_e_taken = 0; m_e_tgt = '0;
      m_bcnt = '0; m_mcnt = '0;
      model_ready = 1;
    end else if (model_ready) begin
      pt  = m_ptaken(PCF);
      ptg = m_ptgt(PCF);
      mis = m_mis();
      act = m_actual();
      if (validE && cflowE && !jalrE) begin
        ix = m_index(PCE);
        if (m_hit(PCE)) begin
          m_ctr[ix] = act ? ((m_ctr[ix] == 3) ? 3 : m_ctr[ix] + 1)
                          : ((m_ctr[ix] == 0) ? 0 : m_ctr[ix] - 1);
          if (act) m_tgt[ix] = targetE;
        end else if (act) begin
          m_valid[ix] = 1; m_tag[ix] = m_tagof(PCE); m_ctr[ix] = 2; m_tgt[ix] = targetE;
        end
        m_bcnt = m_bcnt + 1;
      end
      if (mis) m_mcnt = m_mcnt + 1;
      if (FlushE) begin
        m_e_taken = 0; m_e_tgt = '0;
      end else if (!StallD) begin
        m_e_taken = m_d_taken; m_e_tgt = m_d_tgt;
      end
      if (FlushD) begin
        m_d_taken = 0; m_d_tgt = '0;
      end else if (!StallD) begin
        m_d_taken = pt; m_d_tgt = ptg;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("predict_takenF", {31'd0, predict_takenF}, {31'd0, m_ptaken(PCF)});
      check("pred_targetF",   pred_targetF,   m_ptgt(PCF));
      check("mispredictE",    {31'd0, mispredictE}, {31'd0, m_mis()});
      check("redirect_pcE",   redirect_pcE,   m_actual() ? targetE : PCPlus4E);
      check("branch_cnt",     branch_cnt,     m_bcnt);
      check("mispredict_cnt", mispredict_cnt, m_mcnt);
    end
  end

  // ---------------- directed script ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    PCF = pc; StallD = 0; FlushD = 0; FlushE = 0;
    validE = 0; cflowE = 0; jalrE = 0; takenE = 0;
    targetE = '0; PCE = '0; PCPlus4E = '0;
  endtask

  task automatic resolve(input logic [31:0] pf, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt);
    idle(pf);
    validE = 1; cflowE = 1; takenE = tk; targetE = tgt;
    PCE = pc; PCPlus4E = pc + 32'd4;
  endtask

  task automatic lit_pred(input string n, input logic tk, input logic [31:0] tgt);
    check({n, "_taken"},  {31'd0, predict_takenF}, {31'd0, tk});
    check({n, "_target"}, pred_targetF, tgt);
  endtask

  task automatic lit_cnt(input string n, input int b, input int m);
    check({n, "_branch_cnt"},     branch_cnt,     b);
    check({n, "_mispredict_cnt"}, mispredict_cnt, m);
  endtask

  task automatic lit_mis(input string n, input logic mis);
    check({n, "_mispredictE"}, {31'd0, mispredictE}, {31'd0, mis});
  endtask

  initial begin
    rst = 1;
    idle(32'h100);
    tick(); tick();
    rst = 0;

    // c0: reset state
    idle(32'h100); settle();
    lit_pred("reset", 0, 32'h104); lit_cnt("reset", 0, 0); lit_mis("reset", 0); tick();
    // c1: cold taken branch
    resolve(32'h100, 32'h40, 1, 32'h20); settle();
    lit_mis("cold", 1); check("cold_redirect", redirect_pcE, 32'h20); tick();
    // c2-c3: installed entry predicts taken
    idle(32'h40); settle(); lit_pred("installed", 1, 32'h20); tick();
    idle(32'h40); tick();
    // c4-c6: loop body taken, WT->ST->ST
    for (int i = 0; i < 3; i++) begin
      resolve(32'h40, 32'h40, 1, 32'h20); settle(); lit_mis("loop", 0); tick();
    end
    // c7: loop exit
    resolve(32'h40, 32'h40, 0, 32'h20); settle();
    lit_mis("exit", 1); check("exit_redirect", redirect_pcE, 32'h44); tick();
    // c8: still taken from WT
    idle(32'h40); settle(); lit_pred("after_exit", 1, 32'h20); lit_cnt("after_exit", 5, 2); tick();
    // c9: alias on same index, different tag
    idle(32'h440); settle(); lit_pred("alias", 0, 32'h444); tick();
    // c10-c14: stall holds predD/predE
    idle(32'h40); tick();
    idle(32'h100); StallD = 1; tick();
    idle(32'h100); StallD = 1; tick();
    idle(32'h100); tick();
    resolve(32'h40, 32'h40, 1, 32'h20); settle(); lit_mis("stall_held", 0); tick();
    // c15-c16: FlushE clears a taken prediction
    idle(32'h100); FlushE = 1; tick();
    resolve(32'h100, 32'h40, 0, 32'h20); settle(); lit_mis("flushE", 0); lit_cnt("flushE", 6, 2); tick();
    // c17-c18: bubble trains nothing
    idle(32'h100); cflowE = 1; takenE = 1; PCE = 32'h80; PCPlus4E = 32'h84; targetE = 32'h200; tick();
    idle(32'h80); settle(); lit_pred("bubble", 0, 32'h84); lit_cnt("bubble", 7, 2); tick();
    // c19-c22: JALR with predE taken
    idle(32'h40); tick();
    idle(32'h100); tick();
    idle(32'h100); validE = 1; jalrE = 1; takenE = 1; targetE = 32'h300;
    PCE = 32'h40; PCPlus4E = 32'h44; settle(); lit_mis("jalr", 0); tick();
    idle(32'h40); settle(); lit_pred("jalr_after", 1, 32'h20); lit_cnt("jalr_after", 7, 2); tick();
    // c23-c25: taken with different target
    idle(32'h100); tick();
    resolve(32'h100, 32'h40, 1, 32'h30); settle();
    lit_mis("tgt_change", 1); check("tgt_change_redirect", redirect_pcE, 32'h30); tick();
    idle(32'h40); settle(); lit_pred("tgt_new", 1, 32'h30); lit_cnt("tgt_new", 8, 3); tick();
    // c26-c28: FlushD drops a taken prediction
    idle(32'h40); FlushD = 1; tick();
    idle(32'h100); tick();
    resolve(32'h100, 32'h40, 1, 32'h30); settle(); lit_mis("flushD", 1); tick();
    // c29-c30: mid-operation reset
    resolve(32'h40, 32'h40, 1, 32'h30); rst = 1; tick();
    rst = 0; idle(32'h40); settle();
    lit_pred("rst_mid", 0, 32'h44); lit_cnt("rst_mid", 0, 0); lit_mis("rst_mid", 0); tick();
    idle(32'h100); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
